// File: rtl/fifo_stream_reader_if.sv
// rtl/fifo_stream_reader_if.sv - FIFO read port and output stream bundle for fifo_stream_reader
interface fifo_stream_reader_if #(
  parameter int DATA_LEN = 16
);
  logic                fifo_empty;
  logic [DATA_LEN-1:0] fifo_data;
  logic                read_en;
  logic                m_valid;
  logic [DATA_LEN-1:0] m_data;
  logic                m_ready;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output read_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  read_en, m_valid, m_data
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a 1-cycle-latency FIFO into a valid/ready stream
module fifo_stream_reader #(
  parameter int DATA_LEN  = 16,
  parameter int BUF_DEPTH = 2,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  input  logic                 flush,
  fifo_stream_reader_if.master bus,
  output logic [CNT_WIDTH-1:0] word_count,
  output logic                 busy
);
  localparam int IDX_W = $clog2(BUF_DEPTH);
  localparam int SUM_W = IDX_W + 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUF_DEPTH - 1);

  logic [DATA_LEN-1:0] mem [BUF_DEPTH];
  logic [IDX_W-1:0]    head;
  logic [IDX_W-1:0]    tail;
  logic [SUM_W-1:0]    occ;
  logic [SUM_W-1:0]    level;
  logic                inflight;
  logic                pop_out;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
  endfunction

  // Occupancy the buffer will have next cycle; a new read is only issued if a slot
  // is guaranteed free when its data lands.
  assign pop_out     = bus.m_valid && bus.m_ready;
  assign level       = occ + SUM_W'(inflight) - SUM_W'(pop_out);
  assign bus.read_en = !reset && !flush && !bus.fifo_empty && (level < SUM_W'(BUF_DEPTH));
  assign bus.m_valid = (occ != '0);
  assign bus.m_data  = bus.m_valid ? mem[head] : '0;
  assign busy        = (occ != '0) || inflight;

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      occ        <= '0;
      inflight   <= 1'b0;
      head       <= '0;
      tail       <= '0;
      word_count <= '0;
    end else if (flush) begin
      occ      <= '0;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      if (pop_out) word_count <= word_count + CNT_WIDTH'(1);
    end else begin
      occ      <= level;
      inflight <= bus.read_en;
      if (inflight) tail <= next_idx(tail);
      if (pop_out) begin
        head       <= next_idx(head);
        word_count <= word_count + CNT_WIDTH'(1);
      end
    end
  end

  // Storage needs no reset: m_data is masked while the buffer is empty.
  always_ff @(posedge rd_clk) begin
    if (inflight && !flush) mem[tail] <= bus.fifo_data;
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;
  logic        rd_clk = 1'b0;
  logic        reset  = 1'b1;
  logic        flush  = 1'b0;
  logic [31:0] word_count;
  logic        busy;

  fifo_stream_reader_if #(.DATA_LEN(16)) bus ();

  fifo_stream_reader #(.DATA_LEN(16), .BUF_DEPTH(2), .CNT_WIDTH(32)) dut (
    .rd_clk     (rd_clk),
    .reset      (reset),
    .flush      (flush),
    .bus        (bus.master),
    .word_count (word_count),
    .busy       (busy)
  );

  always #5 rd_clk = ~rd_clk;

  int total = 0;
  int bad   = 0;

  // FIFO model: registered empty flag, data valid the cycle after a pop.
  logic [15:0] fq[$];
  logic [15:0] oq[$];
  bit          hold = 1'b0;
  int          pops = 0;
  int          msz;

  initial begin
    bus.fifo_empty = 1'b1;
    bus.fifo_data  = '0;
    bus.m_ready    = 1'b0;
  end

  always @(posedge rd_clk) begin
    msz = fq.size();
    if (bus.read_en && !bus.fifo_empty) begin
      bus.fifo_data <= fq.pop_front();
      msz  = msz - 1;
      pops = pops + 1;
    end
    bus.fifo_empty <= (msz == 0) || hold;
  end

  always @(posedge rd_clk) begin
    if (!reset && bus.m_valid && bus.m_ready) oq.push_back(bus.m_data);
  end

  task automatic wait_out(input int n, input string name);
    int c = 0;
    while (oq.size() < n && c < 5000) begin
      @(negedge rd_clk);
      c++;
    end
    total++;
    if (oq.size() < n) begin
      bad++;
      $display("FAIL %s timeout: got %0d words, required %0d", name, oq.size(), n);
    end
  endtask

  task automatic test_reset();
    @(negedge rd_clk);
    total += 5;
    if (bus.read_en !== 1'b0) begin bad++; $display("FAIL reset_read_en got=%b exp=0", bus.read_en); end
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", bus.m_valid); end
    if (bus.m_data !== 16'h0) begin bad++; $display("FAIL reset_m_data got=%h exp=0", bus.m_data); end
    if (word_count !== 32'd0) begin bad++; $display("FAIL reset_word_count got=%0d exp=0", word_count); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    reset = 1'b0;
  endtask

  task automatic test_stream();
    int run = 0, first = 0, errs = 0;
    bit ended = 0, gap = 0;
    @(negedge rd_clk);
    oq.delete();
    for (int i = 0; i < 100; i++) fq.push_back(16'(i));
    bus.m_ready = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge rd_clk);
      if (bus.m_valid) begin
        if (ended) gap = 1;
        if (run == 0) first = c;
        run++;
      end else if (run > 0) ended = 1;
    end
    for (int i = 0; i < oq.size() && i < 100; i++) if (oq[i] !== 16'(i)) errs++;
    total += 6;
    if (first != 3) begin bad++; $display("FAIL stream_latency got=%0d exp=3", first); end
    if (run != 100) begin bad++; $display("FAIL stream_valid_run got=%0d exp=100", run); end
    if (gap) begin bad++; $display("FAIL stream_gap got=1 exp=0"); end
    if (oq.size() != 100) begin bad++; $display("FAIL stream_count got=%0d exp=100", oq.size()); end
    if (errs != 0) begin bad++; $display("FAIL stream_order errors=%0d exp=0", errs); end
    if (word_count !== 32'd100) begin bad++; $display("FAIL stream_word_count got=%0d exp=100", word_count); end
  endtask

  task automatic test_stall();
    int base, errs = 0, unstable = 0;
    @(negedge rd_clk);
    bus.m_ready = 1'b0;
    oq.delete();
    base = pops;
    for (int i = 0; i < 10; i++) fq.push_back(16'(i));
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      if (bus.m_data !== 16'h0) unstable++;
    end
    total += 4;
    if (pops - base != 2) begin bad++; $display("FAIL stall_pops got=%0d exp=2", pops - base); end
    if (bus.m_valid !== 1'b1) begin bad++; $display("FAIL stall_m_valid got=%b exp=1", bus.m_valid); end
    if (unstable != 0) begin bad++; $display("FAIL stall_m_data_stable changes=%0d exp=0", unstable); end
    if (oq.size() != 0) begin bad++; $display("FAIL stall_no_accept got=%0d exp=0", oq.size()); end
    bus.m_ready = 1'b1;
    wait_out(10, "stall_drain");
    repeat (4) @(negedge rd_clk);
    for (int i = 0; i < oq.size() && i < 10; i++) if (oq[i] !== 16'(i)) errs++;
    total += 3;
    if (oq.size() != 10) begin bad++; $display("FAIL stall_out_count got=%0d exp=10", oq.size()); end
    if (errs != 0) begin bad++; $display("FAIL stall_order errors=%0d exp=0", errs); end
    if (word_count !== 32'd110) begin bad++; $display("FAIL stall_word_count got=%0d exp=110", word_count); end
  endtask

  task automatic test_empty();
    int rd = 0, vl = 0;
    bus.m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge rd_clk);
      if (bus.read_en) rd++;
      if (bus.m_valid) vl++;
    end
    total += 3;
    if (rd != 0) begin bad++; $display("FAIL empty_read_en cycles=%0d exp=0", rd); end
    if (vl != 0) begin bad++; $display("FAIL empty_m_valid cycles=%0d exp=0", vl); end
    if (word_count !== 32'd110) begin bad++; $display("FAIL empty_word_count got=%0d exp=110", word_count); end
  endtask

  task automatic test_random();
    logic [15:0] w [512];
    int errs = 0, c = 0;
    for (int i = 0; i < 512; i++) w[i] = 16'(i * 16'h0101) ^ 16'h5a5a;
    w[200] = 16'hDEAD;
    w[201] = 16'hDEAD;
    @(negedge rd_clk);
    oq.delete();
    for (int i = 0; i < 512; i++) fq.push_back(w[i]);
    while (oq.size() < 512 && c < 8000) begin
      bus.m_ready = ($urandom_range(1) == 1);
      hold        = ($urandom_range(3) == 0);
      @(negedge rd_clk);
      c++;
    end
    hold = 1'b0;
    bus.m_ready = 1'b1;
    repeat (4) @(negedge rd_clk);
    for (int i = 0; i < oq.size() && i < 512; i++) if (oq[i] !== w[i]) errs++;
    total += 3;
    if (oq.size() != 512) begin bad++; $display("FAIL random_count got=%0d exp=512", oq.size()); end
    if (errs != 0) begin bad++; $display("FAIL random_order errors=%0d exp=0", errs); end
    if (word_count !== 32'd622) begin bad++; $display("FAIL random_word_count got=%0d exp=622", word_count); end
  endtask

  task automatic test_flush();
    int wc0;
    @(negedge rd_clk);
    bus.m_ready = 1'b0;
    oq.delete();
    wc0 = word_count;
    for (int i = 0; i < 6; i++) fq.push_back(16'h0100 + 16'(i));
    repeat (3) @(negedge rd_clk);
    flush = 1'b1;
    @(negedge rd_clk);
    flush = 1'b0;
    total += 3;
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL flush_m_valid got=%b exp=0", bus.m_valid); end
    if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b exp=0", busy); end
    if (word_count !== wc0) begin bad++; $display("FAIL flush_word_count got=%0d exp=%0d", word_count, wc0); end
    bus.m_ready = 1'b1;
    wait_out(4, "flush_drain");
    repeat (4) @(negedge rd_clk);
    total += 3;
    if (oq.size() != 4) begin bad++; $display("FAIL flush_out_count got=%0d exp=4", oq.size()); end
    if (oq.size() > 0 && oq[0] !== 16'h0102) begin bad++; $display("FAIL flush_next_word got=%h exp=0102", oq[0]); end
    if (word_count !== wc0 + 4) begin bad++; $display("FAIL flush_word_count_after got=%0d exp=%0d", word_count, wc0 + 4); end
  endtask

  task automatic test_reset_mid();
    int base, c = 0;
    logic [15:0] exp_head;
    @(negedge rd_clk);
    oq.delete();
    base = word_count;
    for (int i = 0; i < 80; i++) fq.push_back(16'h0200 + 16'(i));
    bus.m_ready = 1'b1;
    while ((word_count - base) < 37 && c < 500) begin
      @(negedge rd_clk);
      c++;
    end
    total++;
    if ((word_count - base) != 37) begin bad++; $display("FAIL midreset_reach got=%0d exp=37", word_count - base); end
    #2 reset = 1'b1;
    #1;
    total += 5;
    if (bus.read_en !== 1'b0) begin bad++; $display("FAIL midreset_read_en got=%b exp=0", bus.read_en); end
    if (bus.m_valid !== 1'b0) begin bad++; $display("FAIL midreset_m_valid got=%b exp=0", bus.m_valid); end
    if (bus.m_data !== 16'h0) begin bad++; $display("FAIL midreset_m_data got=%h exp=0", bus.m_data); end
    if (word_count !== 32'd0) begin bad++; $display("FAIL midreset_word_count got=%0d exp=0", word_count); end
    if (busy !== 1'b0) begin bad++; $display("FAIL midreset_busy got=%b exp=0", busy); end
    exp_head = fq[0];
    @(negedge rd_clk);
    @(negedge rd_clk);
    oq.delete();
    reset = 1'b0;
    wait_out(1, "midreset_first");
    total++;
    if (oq.size() > 0 && oq[0] !== exp_head) begin bad++; $display("FAIL midreset_head got=%h exp=%h", oq[0], exp_head); end
    c = 0;
    while (busy && c < 500) begin
      @(negedge rd_clk);
      c++;
    end
    repeat (4) @(negedge rd_clk);
    total++;
    if (word_count !== 32'(oq.size())) begin bad++; $display("FAIL midreset_count got=%0d exp=%0d", word_count, oq.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_empty();
    test_random();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
